um245r_tx_port: RTL and testbench

//  Downstream output stage for the CSCv2 CPU on the TinyFPGA B. Captures the CPU's
//  A:B output byte on each rising edge of the CPU TX strobe and queues it in a small

---
 rtl/um245r_pkg.sv | 21 ++
 rtl/um245r_tx_port_if.sv | 27 ++
 rtl/um245r_byte_fifo.sv | 47 ++++
 rtl/um245r_tx_port.sv | 142 ++++++++++++++
 tb/tb_um245r_tx_port.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/um245r_pkg.sv
// um245r_pkg: shared FSM state type, CR/LF byte constants and default timing
// for the UM245R transmit port.
package um245r_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      WR_HI,
      WR_LO,
      RECOV
   } tx_state_t;

   localparam logic [7:0] CR_BYTE = 8'h0D;
   localparam logic [7:0] LF_BYTE = 8'h0A;

   localparam int DEF_DEPTH_LOG2   = 4;
   localparam int DEF_WR_CYCLES    = 2;
   localparam int DEF_SETUP_CYCLES = 1;
   localparam int DEF_RECOV_CYCLES = 3;

endpackage

// File: rtl/um245r_tx_port_if.sv
// um245r_tx_port_if: CPU strobe/data inputs and UM245R WR/TXE#/D bus.
// master = port side (drives usb_d/usb_wr), slave = CPU + UM245R side.
interface um245r_tx_port_if;

   logic       tx_strobe;
   logic [7:0] tx_data;
   logic       txe_n;
   logic [7:0] usb_d;
   logic       usb_wr;

   modport master (
      input  tx_strobe,
      input  tx_data,
      input  txe_n,
      output usb_d,
      output usb_wr
   );

   modport slave (
      output tx_strobe,
      output tx_data,
      output txe_n,
      input  usb_d,
      input  usb_wr
   );

endinterface

// File: rtl/um245r_byte_fifo.sv
// um245r_byte_fifo: synchronous byte FIFO of 2**DEPTH_LOG2 entries.
// Ports: clk, Reset (async, high), push/din, pop/dout (head), level, full, empty.
module um245r_byte_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  Reset,
   input  logic                  push,
   input  logic [7:0]            din,
   input  logic                  pop,
   output logic [7:0]            dout,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [7:0]          mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;
   logic                do_push;
   logic                do_pop;

   // Extra pointer bit distinguishes full from empty.
   assign level   = wr_ptr - rd_ptr;
   assign full    = level[DEPTH_LOG2];
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
   end

endmodule

// File: rtl/um245r_tx_port.sv
// um245r_tx_port: captures CPU bytes on tx_strobe edges into a FIFO and drains
// them to a UM245R via WR/TXE#. Ports: clk, Reset (async, high), usb (master
// modport), fifo_level, fifo_full, overflow (sticky). Option UM245R_CRLF_EN
// expands LF into CR,LF.
module um245r_tx_port
   import um245r_pkg::*;
#(
   parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
   parameter int WR_CYCLES    = DEF_WR_CYCLES,
   parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
   parameter int RECOV_CYCLES = DEF_RECOV_CYCLES
) (
   input  logic                clk,
   input  logic                Reset,
   um245r_tx_port_if.master    usb,
   output logic [DEPTH_LOG2:0] fifo_level,
   output logic                fifo_full,
   output logic                overflow
);

   logic       strb_s1, strb_s2, strb_s3;
   logic       txe_s1, txe_s2;
   logic       push, pop, load, empty;
   logic [7:0] head, d_n, usb_d_q;
   logic       usb_wr_q, wr_n;
   logic [7:0] cnt, cnt_n;
   tx_state_t  state, state_n;
`ifdef UM245R_CRLF_EN
   logic       lf_pending;
`endif

   // txe sync resets to 1 so nothing is sent until TXE# is seen low.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         strb_s1 <= 1'b0;
         strb_s2 <= 1'b0;
         strb_s3 <= 1'b0;
         txe_s1  <= 1'b1;
         txe_s2  <= 1'b1;
      end else begin
         strb_s1 <= usb.tx_strobe;
         strb_s2 <= strb_s1;
         strb_s3 <= strb_s2;
         txe_s1  <= usb.txe_n;
         txe_s2  <= txe_s1;
      end
   end

   assign push = strb_s2 & ~strb_s3;

   um245r_byte_fifo #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_fifo (
      .clk  (clk),
      .Reset(Reset),
      .push (push),
      .din  (usb.tx_data),
      .pop  (pop),
      .dout (head),
      .level(fifo_level),
      .full (fifo_full),
      .empty(empty)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pop     = 1'b0;
      load    = 1'b0;
      d_n     = head;
      unique case (state)
         IDLE: begin
            if (!empty && !txe_s2) begin
               load    = 1'b1;
               state_n = SETUP;
               cnt_n   = '0;
`ifdef UM245R_CRLF_EN
               // LF stays at the head until the CR ahead of it is sent.
               if (head == LF_BYTE && !lf_pending) d_n = CR_BYTE;
               else pop = 1'b1;
`else
               pop = 1'b1;
`endif
            end
         end
         SETUP: begin
            if (cnt == 8'(SETUP_CYCLES - 1)) begin
               state_n = WR_HI;
               cnt_n   = '0;
            end else cnt_n = cnt + 8'd1;
         end
         WR_HI: begin
            if (cnt == 8'(WR_CYCLES - 1)) begin
               state_n = WR_LO;
               cnt_n   = '0;
            end else cnt_n = cnt + 8'd1;
         end
         WR_LO: begin
            state_n = RECOV;
            cnt_n   = '0;
         end
         RECOV: begin
            if (cnt == 8'(RECOV_CYCLES - 1)) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else cnt_n = cnt + 8'd1;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
      wr_n = (state_n == WR_HI);
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         usb_wr_q <= 1'b0;
         usb_d_q  <= 8'h00;
         overflow <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         usb_wr_q <= wr_n;
         if (load) usb_d_q <= d_n;
         if (push && fifo_full) overflow <= 1'b1;
      end
   end

`ifdef UM245R_CRLF_EN
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) lf_pending <= 1'b0;
      else if (load) lf_pending <= ~pop;
   end
`endif

   assign usb.usb_d  = usb_d_q;
   assign usb.usb_wr = usb_wr_q;

endmodule

// File: tb/tb_um245r_tx_port.sv
// tb_um245r_tx_port: scoreboard bench; stimulus queues expected WR bytes,
// a negedge monitor checks each WR falling edge against the queue.
module tb_um245r_tx_port;

   logic       clk;
   logic       Reset;
   logic [4:0] fifo_level;
   logic       fifo_full;
   logic       overflow;

   um245r_tx_port_if ifc ();

   um245r_tx_port dut (
      .clk       (clk),
      .Reset     (Reset),
      .usb       (ifc),
      .fifo_level(fifo_level),
      .fifo_full (fifo_full),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         vectors = 0;
   int         miscompares = 0;
   int         pulses = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Expected WR bytes for one captured CPU byte.
   task automatic push_exp(input logic [7:0] b);
`ifdef UM245R_CRLF_EN
      if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(b);
   endtask

   task automatic strobe(input logic [7:0] b, input int hold, input logic expect_out);
      @(posedge clk); #1;
      ifc.tx_data   = b;
      ifc.tx_strobe = 1'b1;
      if (expect_out) push_exp(b);
      repeat (hold) @(posedge clk);
      #1 ifc.tx_strobe = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name, input int max_cyc);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) check(name, 32'(exp_q.size()), 0);
      repeat (10) @(posedge clk);
      #1;
   endtask

   // Monitor: every WR falling edge must match the queue head and be WR_CYCLES wide.
   logic prev_wr = 1'b0;
   int   hi_len = 0;
   always @(negedge clk) begin
      if (Reset) begin
         prev_wr = 1'b0;
         hi_len  = 0;
      end else begin
         if (ifc.usb_wr) hi_len++;
         if (prev_wr && !ifc.usb_wr) begin
            pulses++;
            check("wr_width", 32'(hi_len), 2);
            if (exp_q.size() == 0) check("wr_unexpected", {24'h0, ifc.usb_d}, 32'hFFFF_FFFF);
            else check("wr_data", {24'h0, ifc.usb_d}, {24'h0, exp_q.pop_front()});
            hi_len = 0;
         end
         prev_wr = ifc.usb_wr;
      end
   end

   int p0;
   int n_exp;

   initial begin
      Reset         = 1'b1;
      ifc.tx_strobe = 1'b0;
      ifc.tx_data   = 8'h00;
      ifc.txe_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1 Reset = 1'b0;
      check("rst_wr", {31'h0, ifc.usb_wr}, 0);
      check("rst_d", {24'h0, ifc.usb_d}, 0);
      check("rst_level", {27'h0, fifo_level}, 0);
      check("rst_full", {31'h0, fifo_full}, 0);
      check("rst_ovf", {31'h0, overflow}, 0);
      repeat (5) @(posedge clk);

      // 1: single byte, 3-cycle capture latency
      p0 = pulses;
      @(posedge clk); #1;
      ifc.tx_data   = 8'h41;
      ifc.tx_strobe = 1'b1;
      push_exp(8'h41);
      @(posedge clk); @(posedge clk); #1;
      check("t1_lat2", {27'h0, fifo_level}, 0);
      @(posedge clk); #1;
      check("t1_lat3", {27'h0, fifo_level}, 1);
      @(posedge clk); #1;
      check("t1_popped", {27'h0, fifo_level}, 0);
      ifc.tx_strobe = 1'b0;
      wait_drain("t1_drain", 100);
      check("t1_pulses", 32'(pulses - p0), 1);

      // 2: fill while not ready, overflow, then drain in order
      ifc.txe_n = 1'b1;
      repeat (3) @(posedge clk);
      for (int i = 0; i < 16; i++) strobe(8'(i), 3, 1'b1);
      check("t2_level", {27'h0, fifo_level}, 16);
      check("t2_full", {31'h0, fifo_full}, 1);
      check("t2_ovf0", {31'h0, overflow}, 0);
      strobe(8'hEE, 3, 1'b0);
      check("t2_ovf1", {31'h0, overflow}, 1);
      check("t2_level17", {27'h0, fifo_level}, 16);
      p0    = pulses;
      n_exp = exp_q.size();
      ifc.txe_n = 1'b0;
      wait_drain("t2_drain", 600);
      check("t2_pulses", 32'(pulses - p0), 32'(n_exp));
      check("t2_empty", {27'h0, fifo_level}, 0);

      // 3: held strobe pushes once
      p0 = pulses;
      strobe(8'h55, 50, 1'b1);
      wait_drain("t3_drain", 100);
      check("t3_pulses", 32'(pulses - p0), 1);

      // 4: push and pop in the same cycle at level 3
      ifc.txe_n = 1'b1;
      repeat (3) @(posedge clk);
      strobe(8'h31, 3, 1'b1);
      strobe(8'h32, 3, 1'b1);
      strobe(8'h33, 3, 1'b1);
      check("t4_level3", {27'h0, fifo_level}, 3);
      p0 = pulses;
      @(posedge clk); #1;
      ifc.txe_n     = 1'b0;
      ifc.tx_data   = 8'h34;
      ifc.tx_strobe = 1'b1;
      push_exp(8'h34);
      @(posedge clk); @(posedge clk); #1;
      check("t4_pre", {27'h0, fifo_level}, 3);
      @(posedge clk); #1;
      check("t4_same", {27'h0, fifo_level}, 3);
      ifc.tx_strobe = 1'b0;
      wait_drain("t4_drain", 200);
      check("t4_pulses", 32'(pulses - p0), 4);

      // 5: reset during WR high
      ifc.txe_n = 1'b1;
      repeat (3) @(posedge clk);
      strobe(8'h61, 3, 1'b1);
      strobe(8'h62, 3, 1'b1);
      strobe(8'h63, 3, 1'b1);
      ifc.txe_n = 1'b0;
      begin
         int n;
         n = 0;
         @(posedge clk); #1;
         while (!ifc.usb_wr && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         check("t5_wr_seen", {31'h0, ifc.usb_wr}, 1);
      end
      Reset = 1'b1;
      #1;
      check("t5_wr_drop", {31'h0, ifc.usb_wr}, 0);
      check("t5_level", {27'h0, fifo_level}, 0);
      check("t5_ovf", {31'h0, overflow}, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 Reset = 1'b0;
      p0 = pulses;
      repeat (40) @(posedge clk);
      #1;
      check("t5_no_pulse", 32'(pulses - p0), 0);
      check("t5_d", {24'h0, ifc.usb_d}, 0);

      // 6: LF handling
      p0 = pulses;
      strobe(8'h0A, 3, 1'b1);
`ifdef UM245R_CRLF_EN
      n_exp = 2;
`else
      n_exp = 1;
`endif
      wait_drain("t6_drain", 200);
      check("t6_pulses", 32'(pulses - p0), 32'(n_exp));
      check("t6_level", {27'h0, fifo_level}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
